// File: rtl/msv_pkg.sv
// Shared register map, sprite record and colour helpers for multi_sprite_vga.
package msv_pkg;
  localparam int REG_BG_R      = 0;
  localparam int REG_BG_G      = 1;
  localparam int REG_BG_B      = 2;
  localparam int REG_X_SHIFT   = 3;
  localparam int REG_GROUND    = 4;
  localparam int REG_CTRL      = 5;
  localparam int REG_STATUS    = 6;
  localparam int REG_FRAME_CNT = 7;

  localparam int SPR_BASE   = 8;
  localparam int SPR_STRIDE = 8;
  localparam int SPR_X      = 0;
  localparam int SPR_Y      = 1;
  localparam int SPR_EN     = 2;
  localparam int SPR_COLOR  = 3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        en;
    logic [15:0] color;
  } sprite_t;

  typedef struct packed {
    rgb_t        bg;
    logic [15:0] x_shift;
    logic [15:0] ground;
  } glob_t;

  localparam glob_t GLOB_RST = '{bg: '{r: 8'h00, g: 8'h00, b: 8'h80}, x_shift: 16'h0, ground: 16'h0};

  // Bit replication keeps full-scale 565 values at full-scale 888.
  function automatic rgb_t rgb565_to_888(input logic [15:0] c);
    rgb_t o;
    o.r = {c[15:11], c[15:13]};
    o.g = {c[10:5], c[10:9]};
    o.b = {c[4:0], c[4:2]};
    return o;
  endfunction
endpackage

// File: rtl/vga_counters.sv
// 640x480@60 timing from a 50 MHz clock; hcount runs two ticks per pixel.
module vga_counters (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n
);
  localparam int H_ACTIVE = 1280, H_FRONT = 32, H_SYNC = 192, H_TOTAL = 1600;
  localparam int V_ACTIVE = 480,  V_FRONT = 10, V_SYNC = 2,   V_TOTAL = 525;

  logic end_of_line;
  assign end_of_line = hcount == 11'(H_TOTAL - 1);

  always_ff @(posedge clk or posedge reset)
    if (reset)            hcount <= '0;
    else if (end_of_line) hcount <= '0;
    else                  hcount <= hcount + 11'd1;

  always_ff @(posedge clk or posedge reset)
    if (reset) vcount <= '0;
    else if (end_of_line)
      vcount <= (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;

  assign VGA_HS      = !(hcount >= 11'(H_ACTIVE + H_FRONT) && hcount < 11'(H_ACTIVE + H_FRONT + H_SYNC));
  assign VGA_VS      = !(vcount >= 10'(V_ACTIVE + V_FRONT) && vcount < 10'(V_ACTIVE + V_FRONT + V_SYNC));
  assign VGA_BLANK_n = (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  assign VGA_SYNC_n  = 1'b0;
  assign VGA_CLK     = hcount[0];
endmodule

// File: rtl/multi_sprite_vga.sv
// Avalon-MM sprite renderer: shadow/active register banks, tear-free commit at
// vblank start, fixed-priority sprites over a scrolling ground band.
module multi_sprite_vga
  import msv_pkg::*;
#(
  parameter  int NUM_SPRITES = 4,
  parameter  int SPRITE_W    = 16,
  parameter  int SPRITE_H    = 16,
  parameter  int GROUND_Y    = 400,
  parameter  int STRIPE_LOG2 = 5,
  localparam int ADDR_W      = $clog2(8 + 8*NUM_SPRITES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  input  logic              write,
  input  logic              read,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  output logic              irq,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_n,
  output logic              VGA_SYNC_n
);
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        c_clk, c_hs, c_vs, c_blank_n;

  vga_counters u_cnt (
    .clk(clk), .reset(~reset_n), .hcount(hcount), .vcount(vcount),
    .VGA_CLK(c_clk), .VGA_HS(c_hs), .VGA_VS(c_vs),
    .VGA_BLANK_n(c_blank_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  glob_t                        sh_gl, act_gl;
  sprite_t [NUM_SPRITES-1:0]    sh_spr, act_spr;
  logic                         irq_en, commit_pending, frame_done;
  logic [15:0]                  frame_cnt;
  logic                         wr, rd, gl_sel, status_wr, vbs;
  logic [NUM_SPRITES-1:0]       spr_sel, hit;
  logic [15:0]                  rd_mux;

  assign wr        = chipselect & write;
  assign rd        = chipselect & read;
  assign gl_sel    = 32'(address) < SPR_BASE;
  assign status_wr = wr && gl_sel && address[2:0] == 3'(REG_STATUS);
  assign vbs       = hcount == 11'd0 && vcount == 10'd480;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sel
    assign spr_sel[i] = 32'(address) >= SPR_BASE + SPR_STRIDE*i &&
                        32'(address) <  SPR_BASE + SPR_STRIDE*(i+1);
  end

  // The copy samples shadow values before any same-cycle write lands.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sh_gl          <= GLOB_RST;
      act_gl         <= GLOB_RST;
      sh_spr         <= '0;
      act_spr        <= '0;
      irq_en         <= 1'b0;
      commit_pending <= 1'b0;
      frame_done     <= 1'b0;
      frame_cnt      <= '0;
      irq            <= 1'b0;
    end else begin
      if (vbs) begin
        if (commit_pending) begin
          act_gl  <= sh_gl;
          act_spr <= sh_spr;
        end
        commit_pending <= 1'b0;
        frame_cnt      <= frame_cnt + 16'd1;
      end
      if (status_wr && writedata[0]) commit_pending <= 1'b1;
      if (status_wr && writedata[1]) frame_done <= 1'b0;
      if (vbs)                       frame_done <= 1'b1;
      irq <= frame_done & irq_en;
      if (wr && gl_sel)
        case (address[2:0])
          3'(REG_BG_R):    sh_gl.bg.r    <= writedata[7:0];
          3'(REG_BG_G):    sh_gl.bg.g    <= writedata[7:0];
          3'(REG_BG_B):    sh_gl.bg.b    <= writedata[7:0];
          3'(REG_X_SHIFT): sh_gl.x_shift <= writedata;
          3'(REG_GROUND):  sh_gl.ground  <= writedata;
          3'(REG_CTRL):    irq_en        <= writedata[0];
          default: ;
        endcase
      for (int i = 0; i < NUM_SPRITES; i++)
        if (wr && spr_sel[i])
          case (address[2:0])
            3'(SPR_X):     sh_spr[i].x     <= writedata[9:0];
            3'(SPR_Y):     sh_spr[i].y     <= writedata[9:0];
            3'(SPR_EN):    sh_spr[i].en    <= writedata[0];
            3'(SPR_COLOR): sh_spr[i].color <= writedata;
            default: ;
          endcase
    end

  always_comb begin
    rd_mux = '0;
    if (gl_sel)
      case (address[2:0])
        3'(REG_BG_R):      rd_mux = {8'h0, sh_gl.bg.r};
        3'(REG_BG_G):      rd_mux = {8'h0, sh_gl.bg.g};
        3'(REG_BG_B):      rd_mux = {8'h0, sh_gl.bg.b};
        3'(REG_X_SHIFT):   rd_mux = sh_gl.x_shift;
        3'(REG_GROUND):    rd_mux = sh_gl.ground;
        3'(REG_CTRL):      rd_mux = {15'h0, irq_en};
        3'(REG_STATUS):    rd_mux = {14'h0, frame_done, commit_pending};
        3'(REG_FRAME_CNT): rd_mux = frame_cnt;
        default: ;
      endcase
    for (int i = 0; i < NUM_SPRITES; i++)
      if (spr_sel[i])
        case (address[2:0])
          3'(SPR_X):     rd_mux = {6'h0, sh_spr[i].x};
          3'(SPR_Y):     rd_mux = {6'h0, sh_spr[i].y};
          3'(SPR_EN):    rd_mux = {15'h0, sh_spr[i].en};
          3'(SPR_COLOR): rd_mux = sh_spr[i].color;
          default: ;
        endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else if (rd)  readdata <= rd_mux;

  logic [10:0] col, row;
  logic [15:0] stripe_pos;
  rgb_t        gnd, pix;

  assign col        = {1'b0, hcount[10:1]};
  assign row        = {1'b0, vcount};
  assign stripe_pos = {6'h0, hcount[10:1]} + act_gl.x_shift;
  assign gnd        = rgb565_to_888(act_gl.ground);

  // 11-bit bounds let sprites at the right/bottom edge clip instead of wrap.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    logic [10:0] x0, y0;
    assign x0     = {1'b0, act_spr[i].x};
    assign y0     = {1'b0, act_spr[i].y};
    assign hit[i] = act_spr[i].en && col >= x0 && col < x0 + 11'(SPRITE_W) &&
                    row >= y0 && row < y0 + 11'(SPRITE_H);
  end

  always_comb begin
    pix = act_gl.bg;
    if (row >= 11'(GROUND_Y)) pix = stripe_pos[STRIPE_LOG2] ? ~gnd : gnd;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (hit[i]) pix = rgb565_to_888(act_spr[i].color);
    if (!c_blank_n) pix = '0;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
      VGA_CLK     <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= pix;
      VGA_HS      <= c_hs;
      VGA_VS      <= c_vs;
      VGA_BLANK_n <= c_blank_n;
      VGA_CLK     <= c_clk;
    end
endmodule

// File: tb/tb_multi_sprite_vga.sv
// Directed bench: three frames covering reset, commit, priority, clip, scroll and irq.
module tb_multi_sprite_vga;
  logic        clk, reset_n, write, read, chipselect, irq;
  logic [15:0] writedata, readdata;
  logic [5:0]  address;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  multi_sprite_vga dut (
    .clk(clk), .reset_n(reset_n), .writedata(writedata), .readdata(readdata),
    .write(write), .read(read), .chipselect(chipselect), .address(address),
    .irq(irq), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_n(VGA_BLANK_n), .VGA_SYNC_n(VGA_SYNC_n)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Raster position model: tb_* is the counter value, pix_* the pixel now on the outputs.
  logic [10:0] tb_h, pix_h;
  logic [9:0]  tb_v, pix_v;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tb_h <= '0; tb_v <= '0; pix_h <= '0; pix_v <= '0;
    end else begin
      pix_h <= tb_h;
      pix_v <= tb_v;
      if (tb_h == 11'd1599) begin
        tb_h <= '0;
        tb_v <= (tb_v == 10'd524) ? 10'd0 : tb_v + 10'd1;
      end else tb_h <= tb_h + 11'd1;
    end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic av_write(input int a, input int d);
    address = 6'(a); writedata = 16'(d); write = 1'b1; chipselect = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; chipselect = 1'b0;
  endtask

  task automatic av_read(input int a, output logic [15:0] d);
    address = 6'(a); read = 1'b1; chipselect = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic wait_pos(input int h, input int v);
    int guard = 0;
    while (!(int'(tb_h) == h && int'(tb_v) == v) && guard < 900000) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 900000) chk("wait_pos_timeout", 1, 0);
  endtask

  typedef struct { int c; int r; logic [23:0] rgb; } probe_t;
  probe_t probes[$];

  task automatic add_probe(input int c, input int r, input logic [23:0] rgb);
    probe_t p;
    p.c = c; p.r = r; p.rgb = rgb;
    probes.push_back(p);
  endtask

  // Walks one frame's active rows, counting colour clocks and checking probes.
  task automatic scan_frame(output int n_red, output int n_grn, output int n_blu);
    int guard = 0;
    logic [23:0] rgb;
    n_red = 0; n_grn = 0; n_blu = 0;
    do begin @(posedge clk); #1; guard++; end
    while (!(pix_h == 11'd0 && pix_v == 10'd0) && guard < 900000);
    if (guard >= 900000) chk("frame_start_timeout", 1, 0);
    guard = 0;
    while (!(tb_h == 11'd0 && tb_v == 10'd480) && guard < 900000) begin
      rgb = {VGA_R, VGA_G, VGA_B};
      if (rgb == 24'hFF0000) n_red++;
      if (rgb == 24'h00FF00) n_grn++;
      if (rgb == 24'h0000FF) n_blu++;
      foreach (probes[i])
        if (int'(pix_h) == 2*probes[i].c && int'(pix_v) == probes[i].r)
          chk($sformatf("pix_%0d_%0d", probes[i].c, probes[i].r), rgb, probes[i].rgb);
      @(posedge clk); #1; guard++;
    end
    if (guard >= 900000) chk("frame_end_timeout", 1, 0);
  endtask

  // Called in the VBS cycle: frame_done sets on the next edge, irq one edge later.
  task automatic irq_edge(input string tag);
    chk({tag, "_irq_vbs"}, irq, 0);
    @(posedge clk); #1; chk({tag, "_irq_k1"}, irq, 0);
    @(posedge clk); #1; chk({tag, "_irq_k2"}, irq, 1);
  endtask

  localparam logic [23:0] BG = 24'h000080, WH = 24'hFFFFFF, BK = 24'h000000;
  localparam logic [23:0] RD = 24'hFF0000, GR = 24'h00FF00, BL = 24'h0000FF;

  logic [15:0] d;
  int nr, ng, nb;

  initial begin
    reset_n = 1'b0; write = 1'b0; read = 1'b0; chipselect = 1'b0;
    address = '0; writedata = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_irq", irq, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
    @(negedge clk); reset_n = 1'b1;

    // Frame 0: sprite written to shadow only; commit issued late in the frame.
    add_probe(10, 10, BG); add_probe(100, 50, BG);
    add_probe(10, 420, BK); add_probe(10, 479, BK);
    fork
      scan_frame(nr, ng, nb);
      begin
        av_read(6, d); chk("rst_status", d, 0);
        av_read(2, d); chk("rst_bg_b", d, 16'h0080);
        av_write(8, 100); av_write(9, 50); av_write(10, 1); av_write(11, 'hF800);
        av_write(4, 'hFFFF); av_write(3, 0); av_write(5, 1);
        av_read(8, d); chk("shadow_x0", d, 100);
        wait_pos(0, 470);
        av_write(6, 1);
        av_read(6, d); chk("status_pending", d, 1);
      end
    join
    chk("f0_red", nr, 0);
    irq_edge("vbs0");
    av_read(6, d); chk("vbs0_status", d, 2);
    av_read(7, d); chk("vbs0_frame_cnt", d, 1);
    av_write(6, 2);
    av_read(6, d); chk("vbs0_status_clr", d, 0);
    repeat (2) @(posedge clk); #1;
    chk("vbs0_irq_clr", irq, 0);

    // Frame 1: sprite0 plus stripes at X_SHIFT=0; stage overlap/clip/scroll.
    probes.delete();
    add_probe(100, 50, RD); add_probe(115, 65, RD); add_probe(99, 50, BG);
    add_probe(116, 50, BG); add_probe(100, 66, BG); add_probe(115, 49, BG);
    add_probe(0, 420, WH); add_probe(31, 420, WH); add_probe(32, 420, BK); add_probe(63, 420, BK);
    fork
      scan_frame(nr, ng, nb);
      begin
        av_write(16, 108); av_write(17, 50); av_write(18, 1); av_write(19, 'h07E0);
        av_write(24, 632); av_write(25, 472); av_write(26, 1); av_write(27, 'h001F);
        av_write(3, 16);
        av_read(16, d); chk("shadow_x1", d, 108);
        wait_pos(0, 470);
        av_write(6, 1);
      end
    join
    chk("f1_red", nr, 512);
    chk("f1_grn", ng, 0);
    chk("f1_blu", nb, 0);
    irq_edge("vbs1");
    av_read(7, d); chk("vbs1_frame_cnt", d, 2);
    av_read(6, d); chk("vbs1_status", d, 2);
    av_write(6, 2);

    // Frame 2: priority overlap, edge clip, scroll by 16, reserved/unmapped reads.
    probes.delete();
    add_probe(100, 50, RD); add_probe(115, 65, RD); add_probe(116, 50, GR);
    add_probe(123, 65, GR); add_probe(124, 50, BG);
    add_probe(632, 472, BL); add_probe(639, 479, BL); add_probe(631, 472, WH);
    add_probe(632, 471, WH); add_probe(0, 472, WH); add_probe(0, 0, BG); add_probe(7, 7, BG);
    add_probe(0, 420, WH); add_probe(15, 420, WH); add_probe(16, 420, BK);
    add_probe(47, 420, BK); add_probe(48, 420, WH);
    fork
      scan_frame(nr, ng, nb);
      begin
        av_read(12, d); chk("reserved_rd", d, 0);
        av_write(12, 'hFFFF);
        av_read(12, d); chk("reserved_wr", d, 0);
        av_read(63, d); chk("unmapped_rd", d, 0);
        av_read(6, d); chk("f2_status_clr", d, 0);
      end
    join
    chk("f2_red", nr, 512);
    chk("f2_grn", ng, 256);
    chk("f2_blu", nb, 128);
    // Commit request and frame_done clear both land in the VBS cycle.
    av_write(6, 3);
    av_read(6, d); chk("vbs2_collide_status", d, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
